dmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves the CPU's load/store port over a valid/ready request and single-cycle response handshake. It replaces the zero-latency data-memory path so the core can be tested against realistic memory latency. The block latches one request, counts a programmable number of wait states, then commits the write or returns read data. Storage is word-organised and is not cleared by reset.

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 119 +++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory responder
package dmem_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int WORD_W     = 32;

    localparam logic [WORD_W-1:0] ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word storage, asynchronous read and synchronous write, not cleared by reset
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with programmable wait states
// DMEM_ALIGN_CHECK_EN: when defined, misaligned addresses fault instead of hitting the containing word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
        (WAIT_STATES == 0) ? '0 : WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                state;
    state_t                state_next;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cnt_next;

    logic                  we_q;
    logic                  err_q;
    logic [AW-1:0]         idx_q;
    logic [WORD_W-1:0]     wdata_q;

    logic                  accept;
    logic                  range_err;
    logic                  align_err;
    logic                  wr_en;
    logic [WORD_W-1:0]     rd_data;

    assign accept    = req_valid && (state == IDLE);
    assign range_err = ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign align_err = |req_addr[1:0];
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[1:0];
    assign align_err        = 1'b0;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured only at acceptance so later req_* activity cannot disturb them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q    <= req_we;
                err_q   <= range_err || align_err;
                idx_q   <= req_addr[AW+1:2];
                wdata_q <= req_wdata;
            end
        end
    end

    // A reset landing on the RESP edge must abort the store as well.
    assign wr_en = (state == RESP) && we_q && !err_q && !reset;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_idx (idx_q),
        .wr_data(wdata_q),
        .rd_idx (idx_q),
        .rd_data(rd_data)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? rd_data : ERR_RDATA;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench against a word-array reference model
module tb_dmem_responder;

    localparam int DEPTH  = 64;
    localparam int WS     = 2;
    localparam int DEPTH0 = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;

    logic        d0_req_valid, d0_req_ready, d0_req_we, d0_resp_valid, d0_resp_err;
    logic [31:0] d0_req_addr, d0_req_wdata, d0_resp_rdata;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(d0_req_valid), .req_ready(d0_req_ready), .req_we(d0_req_we),
        .req_addr(d0_req_addr), .req_wdata(d0_req_wdata),
        .resp_valid(d0_resp_valid), .resp_rdata(d0_resp_rdata), .resp_err(d0_resp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit exp_err(input logic [31:0] addr);
        return (addr[31:2] >= 30'(DEPTH)) || (ALIGN_EN && (addr[1:0] != 2'b00));
    endfunction

    // Entered and left just after a falling edge with the responder idle.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit scramble);
        int          lat;
        bit          got;
        logic [31:0] rd;
        logic        er;
        bit          e;
        logic [31:0] exp_rd;
        check_eq("ready_before", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        got = 1'b0;
        lat = 0;
        rd  = '0;
        er  = 1'b0;
        for (int c = 1; c <= WS + 6 && !got; c++) begin
            @(negedge clk);
            check_eq("ready_busy", 32'(req_ready), 32'd0);
            if (resp_valid) begin
                got = 1'b1;
                lat = c;
                rd  = resp_rdata;
                er  = resp_err;
                req_valid = 1'b0;
            end else if (scramble) begin
                req_valid = 1'($urandom);
                req_we    = 1'($urandom);
                req_addr  = $urandom;
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check_eq("resp_latency", 32'(lat), 32'(WS + 1));
        e = exp_err(addr);
        check_eq("resp_err", 32'(er), 32'(e));
        if (we) begin
            exp_rd = 32'h0;
            if (!e) model[int'(addr[31:2])] = wdata;
        end else begin
            exp_rd = e ? 32'h0 : model[int'(addr[31:2])];
        end
        check_eq(we ? "store_rdata" : "load_rdata", rd, exp_rd);
        @(negedge clk);
        check_eq("ready_after", 32'(req_ready), 32'd1);
        check_eq("resp_single", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] vals [2];
        logic [31:0] a;
        int          r;

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0;
        req_wdata = 32'hFFFF_FFFF;
        d0_req_valid = 1'b0;
        d0_req_we    = 1'b0;
        d0_req_addr  = 32'h0;
        d0_req_wdata = 32'h0;

        // Request held during reset must not be accepted.
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'h0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        reset     = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < WS + 3; i++) begin
            @(negedge clk);
            check_eq("no_resp_post_reset", 32'(resp_valid), 32'd0);
        end

        for (int i = 0; i < DEPTH; i++) txn(1'b1, 32'(i * 4), $urandom, 1'b0);

        txn(1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
        txn(1'b0, 32'h10, 32'h0, 1'b0);

        txn(1'b0, 32'(4 * DEPTH), 32'h0, 1'b0);
        txn(1'b1, 32'(4 * DEPTH), 32'hCAFEF00D, 1'b0);
        txn(1'b0, 32'h0, 32'h0, 1'b0);
        txn(1'b0, 32'(4 * (DEPTH - 1)), 32'h0, 1'b0);

        // Reset in WAIT aborts the store.
        txn(1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_in_wait", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_eq("ready_after_reset", 32'(req_ready), 32'd1);
        check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
        for (int i = 0; i < WS + 2; i++) begin
            @(negedge clk);
            check_eq("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        txn(1'b0, 32'h20, 32'h0, 1'b0);

        txn(1'b1, 32'h30, 32'h0BADF00D, 1'b1);
        txn(1'b0, 32'h30, 32'h0, 1'b1);

        txn(1'b1, 32'h22, 32'h77778888, 1'b0);
        txn(1'b0, 32'h20, 32'h0, 1'b0);

        for (int i = 0; i < 150; i++) begin
            r = int'($urandom_range(0, 7));
            if (r < 6)       a = {24'h0, 6'($urandom), 2'($urandom)};
            else if (r == 6) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else             a = $urandom;
            txn(1'($urandom), a, $urandom, 1'($urandom));
        end

        // Zero-wait instance: req_valid held high, alternating store/load.
        vals[0] = $urandom;
        vals[1] = $urandom;
        d0_req_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                check_eq("z_ready_idle", 32'(d0_req_ready), 32'd1);
                check_eq("z_valid_idle", 32'(d0_resp_valid), 32'd0);
                d0_req_we    = ((k / 2) % 2 == 0);
                d0_req_addr  = 32'(4 * (k / 4));
                d0_req_wdata = vals[k / 4];
            end else begin
                check_eq("z_ready_resp", 32'(d0_req_ready), 32'd0);
                check_eq("z_valid_resp", 32'(d0_resp_valid), 32'd1);
                check_eq("z_err", 32'(d0_resp_err), 32'd0);
                check_eq("z_rdata", d0_resp_rdata,
                         (((k / 2) % 2) == 0) ? 32'h0 : vals[k / 4]);
            end
            @(negedge clk);
        end
        d0_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
